// File: rtl/cd_sector_buf_if.sv
// Loader, CDC and DMA signal bundle for cd_sector_buf.
// The slave modport is the buffer; the master modport drives it (loader/CDC/DMA side).
interface cd_sector_buf_if;
  logic        LOAD_WR;
  logic [15:0] LOAD_DATA;
  logic        LOAD_READY;
  logic        OVERFLOW;
  logic        OVF_CLR;
  logic [31:0] HEADER_DOUT;
  logic        SECTOR_READY;
  logic        DMA_START;
  logic [10:0] DMA_LEN;
  logic        DMA_RD;
  logic [15:0] DMA_DOUT;
  logic        DMA_RUNNING;
  logic [1:0]  BANKS_FULL;

  modport slave (
    input  LOAD_WR, LOAD_DATA, OVF_CLR, DMA_START, DMA_LEN, DMA_RD,
    output LOAD_READY, OVERFLOW, HEADER_DOUT, SECTOR_READY, DMA_DOUT, DMA_RUNNING, BANKS_FULL
  );

  modport master (
    output LOAD_WR, LOAD_DATA, OVF_CLR, DMA_START, DMA_LEN, DMA_RD,
    input  LOAD_READY, OVERFLOW, HEADER_DOUT, SECTOR_READY, DMA_DOUT, DMA_RUNNING, BANKS_FULL
  );
endinterface

// File: rtl/cd_sector_buf.sv
// Ping-pong sector buffer ahead of the CDC: DMA_DOUT follows DMA_RD by one cycle; loader writes are
// dropped (sticky OVERFLOW) while LOAD_READY is low. CD_RAW_SECTOR_EN selects 1176-word raw sectors.
module cd_sector_buf #(
  parameter logic [15:0] READY_HOLD = 16'd64,
  parameter logic [10:0] DATA_WORDS = 11'd1024
) (
  input  logic          clk_sys,
  input  logic          nRESET,
  cd_sector_buf_if.slave bus
);

`ifdef CD_RAW_SECTOR_EN
  localparam int WI_W     = 12;
  localparam int HDR_IDX  = 6;
  localparam int LAST_IDX = 1175;
`else
  localparam int WI_W     = 11;
  localparam int HDR_IDX  = 0;
  localparam int LAST_IDX = int'(DATA_WORDS) + 1;
`endif
  localparam int DATA_FIRST = HDR_IDX + 2;
  localparam int DATA_END   = DATA_FIRST + int'(DATA_WORDS);

  typedef enum logic [1:0] {RDY_IDLE, RDY_HOLD, RDY_GAP} rdy_state_t;
  typedef enum logic       {DMA_IDLE, DMA_RUN} dma_state_t;

  logic [15:0]     ram [0:2047];
  logic [31:0]     hdr_bank [2];
  logic [15:0]     hdr_lo;
  logic [WI_W-1:0] wi;
  logic            wb, rb, ann_bank;
  logic [1:0]      full, full_d;
  logic [1:0]      banks_full;
  logic [1:0]      pending, pending_d;
  logic            ovf;

  logic            load_ready, wr_ok, fill_done, ram_we;
  logic [9:0]      ram_waddr;

  rdy_state_t      rdy_state, rdy_state_d;
  logic [15:0]     rdy_cnt, rdy_cnt_d;
  logic            sector_ready, sector_ready_d;
  logic [31:0]     header, header_d;
  logic            pop;

  dma_state_t      dma_state, dma_state_d;
  logic [10:0]     dma_cnt, dma_cnt_d, eff_len;
  logic [9:0]      rd_addr, rd_addr_d;
  logic            running, running_d;
  logic            rd_en, release_bank;
  logic [15:0]     dout;

  assign load_ready = ~full[wb];
  assign wr_ok      = bus.LOAD_WR & load_ready;
  assign fill_done  = wr_ok && (wi == WI_W'(LAST_IDX));
  assign ram_we     = wr_ok && (wi >= WI_W'(DATA_FIRST)) && (wi < WI_W'(DATA_END));
  assign ram_waddr  = 10'(wi - WI_W'(DATA_FIRST));

  // Write side: header words are staged and stored byte-swapped as {mode,frame,sec,min}.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      wi          <= '0;
      wb          <= 1'b0;
      hdr_lo      <= '0;
      hdr_bank[0] <= '0;
      hdr_bank[1] <= '0;
      ovf         <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (wi == WI_W'(HDR_IDX))
          hdr_lo <= bus.LOAD_DATA;
        if (wi == WI_W'(HDR_IDX + 1))
          hdr_bank[wb] <= {bus.LOAD_DATA[7:0], bus.LOAD_DATA[15:8], hdr_lo[7:0], hdr_lo[15:8]};
        if (fill_done) begin
          wi <= '0;
          wb <= ~wb;
        end else begin
          wi <= wi + 1'b1;
        end
      end
      if (bus.OVF_CLR)
        ovf <= 1'b0;
      else if (bus.LOAD_WR && !load_ready)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (ram_we)
      ram[{wb, ram_waddr}] <= bus.LOAD_DATA;
  end

  // A fill and a release in the same cycle always target different banks.
  always_comb begin
    full_d = full;
    if (fill_done)    full_d[wb] = 1'b1;
    if (release_bank) full_d[rb] = 1'b0;
  end

  always_comb begin
    pending_d = pending;
    if (fill_done && !pop) begin
      if (pending != 2'd2) pending_d = pending + 2'd1;
    end else if (!fill_done && pop) begin
      pending_d = pending - 2'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      full       <= '0;
      banks_full <= '0;
      rb         <= 1'b0;
      pending    <= '0;
      ann_bank   <= 1'b0;
    end else begin
      full       <= full_d;
      banks_full <= {1'b0, full_d[0]} + {1'b0, full_d[1]};
      pending    <= pending_d;
      if (release_bank) rb       <= ~rb;
      if (pop)          ann_bank <= ~ann_bank;
    end
  end

  // Ready FSM: fixed-width high pulse followed by an equal low gap so the CDC sees a clean edge.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      rdy_state    <= RDY_IDLE;
      rdy_cnt      <= '0;
      sector_ready <= 1'b0;
      header       <= '0;
    end else begin
      rdy_state    <= rdy_state_d;
      rdy_cnt      <= rdy_cnt_d;
      sector_ready <= sector_ready_d;
      header       <= header_d;
    end
  end

  always_comb begin
    rdy_state_d    = rdy_state;
    rdy_cnt_d      = rdy_cnt;
    sector_ready_d = sector_ready;
    header_d       = header;
    pop            = 1'b0;
    unique case (rdy_state)
      RDY_IDLE: begin
        if (pending != 2'd0) begin
          rdy_state_d    = RDY_HOLD;
          rdy_cnt_d      = '0;
          sector_ready_d = 1'b1;
          header_d       = hdr_bank[ann_bank];
          pop            = 1'b1;
        end
      end
      RDY_HOLD: begin
        if (rdy_cnt == READY_HOLD - 16'd1) begin
          rdy_state_d    = RDY_GAP;
          rdy_cnt_d      = '0;
          sector_ready_d = 1'b0;
        end else begin
          rdy_cnt_d = rdy_cnt + 16'd1;
        end
      end
      RDY_GAP: begin
        if (rdy_cnt == READY_HOLD - 16'd1) begin
          rdy_state_d = RDY_IDLE;
          rdy_cnt_d   = '0;
        end else begin
          rdy_cnt_d = rdy_cnt + 16'd1;
        end
      end
      default: rdy_state_d = RDY_IDLE;
    endcase
  end

  assign eff_len = (bus.DMA_LEN == 11'd0 || bus.DMA_LEN > DATA_WORDS) ? DATA_WORDS : bus.DMA_LEN;

  // DMA FSM: release waits one cycle after the last read so its data is already on DMA_DOUT.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      dma_state <= DMA_IDLE;
      dma_cnt   <= '0;
      rd_addr   <= '0;
      running   <= 1'b0;
      dout      <= '0;
    end else begin
      dma_state <= dma_state_d;
      dma_cnt   <= dma_cnt_d;
      rd_addr   <= rd_addr_d;
      running   <= running_d;
      if (rd_en)
        dout <= ram[{rb, rd_addr}];
    end
  end

  always_comb begin
    dma_state_d  = dma_state;
    dma_cnt_d    = dma_cnt;
    rd_addr_d    = rd_addr;
    running_d    = running;
    rd_en        = 1'b0;
    release_bank = 1'b0;
    case (dma_state)
      DMA_IDLE: begin
        if (bus.DMA_START && full[rb]) begin
          dma_state_d = DMA_RUN;
          dma_cnt_d   = eff_len;
          rd_addr_d   = '0;
          running_d   = 1'b1;
        end
      end
      DMA_RUN: begin
        if (dma_cnt == 11'd0) begin
          dma_state_d  = DMA_IDLE;
          running_d    = 1'b0;
          release_bank = 1'b1;
        end else if (bus.DMA_RD) begin
          rd_en     = 1'b1;
          rd_addr_d = rd_addr + 10'd1;
          dma_cnt_d = dma_cnt - 11'd1;
        end
      end
    endcase
  end

  assign bus.LOAD_READY   = load_ready;
  assign bus.OVERFLOW     = ovf;
  assign bus.HEADER_DOUT  = header;
  assign bus.SECTOR_READY = sector_ready;
  assign bus.DMA_DOUT     = dout;
  assign bus.DMA_RUNNING  = running;
  assign bus.BANKS_FULL   = banks_full;

endmodule

// File: tb/tb_cd_sector_buf.sv
// Bench for cd_sector_buf: DMA length table plus overflow, fill/release collision and reset sequences.
module tb_cd_sector_buf;
`ifdef CD_RAW_SECTOR_EN
  localparam int SW  = 1176;
  localparam int HDR = 6;
`else
  localparam int SW  = 1026;
  localparam int HDR = 0;
`endif

  typedef struct packed {logic [7:0] mn, sc, fr, md; logic [15:0] base;} sec_t;
  typedef struct {sec_t s; logic [10:0] len; int n; logic [31:0] hdr;} vec_t;

  localparam sec_t S1 = {8'h20, 8'h01, 8'h05, 8'h01, 16'h3000};
  localparam sec_t S2 = {8'h20, 8'h01, 8'h06, 8'h01, 16'h4000};
  localparam sec_t S3 = {8'h20, 8'h01, 8'h07, 8'h01, 16'h5000};
  localparam sec_t S4 = {8'h20, 8'h01, 8'h08, 8'h01, 16'h6000};
  localparam sec_t S5 = {8'h31, 8'h22, 8'h13, 8'h01, 16'h7000};
  localparam sec_t S6 = {8'h31, 8'h22, 8'h14, 8'h01, 16'h8000};
  localparam sec_t S7 = {8'h31, 8'h22, 8'h15, 8'h01, 16'h9000};

  logic clk_sys = 1'b0;
  logic nRESET;
  always #5 clk_sys = ~clk_sys;

  cd_sector_buf_if bus();
  cd_sector_buf dut (.clk_sys(clk_sys), .nRESET(nRESET), .bus(bus));

  int          n_cmp = 0, n_bad = 0, pulse_cnt = 0, exp_pulses = 0;
  logic [31:0] hdr_q[$];
  logic [15:0] exp_q[$];
  vec_t        vec [6];
  logic [15:0] last_word;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_ge(input string nm, input int act, input int lo);
    n_cmp++;
    if (act < lo) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected at least %0d", nm, act, lo);
    end
  endtask

  function automatic logic [15:0] sec_word(input sec_t s, input int idx);
    if (idx < HDR)                return 16'hFFFF - 16'(idx);
    else if (idx == HDR)          return {s.mn, s.sc};
    else if (idx == HDR + 1)      return {s.fr, s.md};
    else if (idx < HDR + 2 + 1024) return s.base + 16'(idx - HDR - 2);
    else                          return 16'hEC00 + 16'(idx);
  endfunction

  function automatic logic [31:0] hdr_of(input sec_t s);
    return {s.md, s.fr, s.sc, s.mn};
  endfunction

  // SECTOR_READY monitor: header scoreboard at each rising edge, pulse width and gap.
  logic sr_prev = 1'b0;
  int   hi_len = 0, lo_len = 0;
  bit   seen = 1'b0;
  always @(negedge clk_sys) begin
    if (!nRESET) begin
      sr_prev = 1'b0; hi_len = 0; lo_len = 0; seen = 1'b0;
    end else begin
      if (bus.SECTOR_READY && !sr_prev) begin
        pulse_cnt++;
        if (seen) check_ge("ready_gap", lo_len, 64);
        if (hdr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ready_unexpected: got pulse with header %0h, expected no pulse", bus.HEADER_DOUT);
        end else begin
          check("header_dout", bus.HEADER_DOUT, hdr_q.pop_front());
        end
        hi_len = 1;
      end else if (bus.SECTOR_READY) begin
        hi_len++;
      end else if (sr_prev) begin
        check("ready_width", hi_len, 64);
        seen = 1'b1;
        lo_len = 1;
      end else begin
        lo_len++;
      end
      sr_prev = bus.SECTOR_READY;
    end
  end

  task automatic load_range(input sec_t s, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      bus.LOAD_WR   = 1'b1;
      bus.LOAD_DATA = sec_word(s, i);
      @(posedge clk_sys); #1;
    end
    bus.LOAD_WR = 1'b0;
  endtask

  task automatic load_sector(input sec_t s, input logic [31:0] h);
    hdr_q.push_back(h);
    exp_pulses++;
    load_range(s, 0, SW - 1);
  endtask

  task automatic dma_start(input logic [10:0] len);
    bus.DMA_LEN   = len;
    bus.DMA_START = 1'b1;
    @(posedge clk_sys); #1;
    bus.DMA_START = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic dma_read(input logic [15:0] exp);
    bus.DMA_RD = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk_sys); #1;
    bus.DMA_RD = 1'b0;
    @(negedge clk_sys);
    check("dma_dout", bus.DMA_DOUT, exp_q.pop_front());
  endtask

  task automatic dma_xfer(input logic [15:0] base, input logic [10:0] len, input int n,
                          input logic [1:0] full_after);
    dma_start(len);
    check("dma_running_start", 32'(bus.DMA_RUNNING), 1);
    for (int i = 0; i < n; i++) dma_read(base + 16'(i));
    check("dma_running_last", 32'(bus.DMA_RUNNING), 1);
    @(posedge clk_sys); #1;
    @(negedge clk_sys);
    check("dma_running_end", 32'(bus.DMA_RUNNING), 0);
    check("banks_full_release", 32'(bus.BANKS_FULL), 32'(full_after));
  endtask

  task automatic wait_pulses(input int n);
    for (int i = 0; i < 3000 && pulse_cnt < n; i++) @(negedge clk_sys);
    check("pulse_count", pulse_cnt, n);
  endtask

  initial begin
    vec[0] = '{sec_t'({8'h00, 8'h02, 8'h10, 8'h01, 16'h0000}), 11'd0,    1024, 32'h01100200};
    vec[1] = '{sec_t'({8'h12, 8'h34, 8'h56, 8'h02, 16'h1000}), 11'd4,    4,    32'h02563412};
    vec[2] = '{sec_t'({8'h00, 8'h00, 8'h00, 8'h01, 16'hA5A0}), 11'd1,    1,    32'h01000000};
    vec[3] = '{sec_t'({8'h59, 8'h59, 8'h74, 8'h01, 16'h7FF0}), 11'd1025, 1024, 32'h01745959};
    vec[4] = '{sec_t'({8'h01, 8'h02, 8'h03, 8'h01, 16'h2000}), 11'd2047, 1024, 32'h01030201};
    vec[5] = '{sec_t'({8'h44, 8'h33, 8'h22, 8'h01, 16'hFFF8}), 11'd1024, 1024, 32'h01223344};

    bus.LOAD_WR = 1'b0; bus.LOAD_DATA = '0; bus.OVF_CLR = 1'b0;
    bus.DMA_START = 1'b0; bus.DMA_LEN = '0; bus.DMA_RD = 1'b0;
    nRESET = 1'b1;
    #2 nRESET = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_load_ready", 32'(bus.LOAD_READY), 1);
    check("rst_overflow", 32'(bus.OVERFLOW), 0);
    check("rst_header", bus.HEADER_DOUT, 0);
    check("rst_sector_ready", 32'(bus.SECTOR_READY), 0);
    check("rst_dma_dout", 32'(bus.DMA_DOUT), 0);
    check("rst_dma_running", 32'(bus.DMA_RUNNING), 0);
    check("rst_banks_full", 32'(bus.BANKS_FULL), 0);
    nRESET = 1'b1;
    @(posedge clk_sys); #1;

    dma_start(11'd0);
    check("dma_start_no_bank", 32'(bus.DMA_RUNNING), 0);

    for (int v = 0; v < 6; v++) begin
      load_sector(vec[v].s, vec[v].hdr);
      @(negedge clk_sys);
      check("load_ready_one_full", 32'(bus.LOAD_READY), 1);
      check("banks_full_one", 32'(bus.BANKS_FULL), 1);
      dma_xfer(vec[v].s.base, vec[v].len, vec[v].n, 2'd0);
      last_word = vec[v].s.base + 16'(vec[v].n - 1);
    end

    bus.DMA_RD = 1'b1;
    @(posedge clk_sys); #1;
    bus.DMA_RD = 1'b0;
    @(negedge clk_sys);
    check("dout_hold_idle", 32'(bus.DMA_DOUT), 32'(last_word));

    // Three sectors with no DMA: the third is refused.
    load_sector(S1, hdr_of(S1));
    @(negedge clk_sys);
    check("ovf_ready_after_s1", 32'(bus.LOAD_READY), 1);
    load_sector(S2, hdr_of(S2));
    @(negedge clk_sys);
    check("ovf_ready_after_s2", 32'(bus.LOAD_READY), 0);
    check("ovf_banks_full", 32'(bus.BANKS_FULL), 2);
    check("ovf_clear_before", 32'(bus.OVERFLOW), 0);
    load_range(S3, 0, 0);
    @(negedge clk_sys);
    check("ovf_set", 32'(bus.OVERFLOW), 1);
    bus.OVF_CLR = 1'b1; bus.LOAD_WR = 1'b1; bus.LOAD_DATA = 16'h1234;
    @(posedge clk_sys); #1;
    bus.OVF_CLR = 1'b0; bus.LOAD_WR = 1'b0;
    @(negedge clk_sys);
    check("ovf_clr_priority", 32'(bus.OVERFLOW), 0);
    wait_pulses(exp_pulses);

    // Short DMA on S1, then S4's last word lands on the cycle S2 is released.
    dma_xfer(S1.base, 11'd4, 4, 2'd1);
    check("sim_load_ready_pre", 32'(bus.LOAD_READY), 1);
    hdr_q.push_back(hdr_of(S4));
    exp_pulses++;
    load_range(S4, 0, SW - 2);
    dma_start(11'd2);
    dma_read(S2.base);
    bus.DMA_RD = 1'b1;
    exp_q.push_back(S2.base + 16'd1);
    @(posedge clk_sys); #1;
    bus.DMA_RD = 1'b0;
    bus.LOAD_WR = 1'b1;
    bus.LOAD_DATA = sec_word(S4, SW - 1);
    @(negedge clk_sys);
    check("dma_dout", 32'(bus.DMA_DOUT), 32'(exp_q.pop_front()));
    check("sim_banks_full_before", 32'(bus.BANKS_FULL), 1);
    @(posedge clk_sys); #1;
    bus.LOAD_WR = 1'b0;
    @(negedge clk_sys);
    check("sim_banks_full_after", 32'(bus.BANKS_FULL), 1);
    check("sim_dma_released", 32'(bus.DMA_RUNNING), 0);
    check("sim_load_ready_post", 32'(bus.LOAD_READY), 1);
    dma_xfer(S4.base, 11'd0, 1024, 2'd0);

    // Reset mid-pulse, mid-DMA and mid-fill.
    repeat (150) @(negedge clk_sys);
    load_sector(S5, hdr_of(S5));
    dma_start(11'd0);
    for (int i = 0; i < 3; i++) dma_read(S5.base + 16'(i));
    load_range(S6, 0, 19);
    @(negedge clk_sys);
    check("sr_before_reset", 32'(bus.SECTOR_READY), 1);
    check("run_before_reset", 32'(bus.DMA_RUNNING), 1);
    #2 nRESET = 1'b0;
    #1;
    check("arst_sector_ready", 32'(bus.SECTOR_READY), 0);
    check("arst_dma_running", 32'(bus.DMA_RUNNING), 0);
    check("arst_load_ready", 32'(bus.LOAD_READY), 1);
    check("arst_banks_full", 32'(bus.BANKS_FULL), 0);
    check("arst_dma_dout", 32'(bus.DMA_DOUT), 0);
    check("arst_header", bus.HEADER_DOUT, 0);
    hdr_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk_sys);
    nRESET = 1'b1;
    @(posedge clk_sys); #1;
    load_sector(S7, hdr_of(S7));
    @(negedge clk_sys);
    check("post_rst_banks_full", 32'(bus.BANKS_FULL), 1);
    dma_xfer(S7.base, 11'd4, 4, 2'd0);

    wait_pulses(exp_pulses);
    repeat (140) @(negedge clk_sys);
    check("hdr_queue_drained", hdr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cd_sector_buf.md
Name: cd_sector_buf

Overview:
- Ping-pong sector buffer directly upstream of the LC8951 CDC model in the Neo CD path.
- Accepts a 16-bit word stream of Mode-1 sectors from the loader and latches each sector's 4-byte header.
- Raises SECTOR_READY/HEADER_DOUT for the CDC, then serves the sector's 2048 data bytes to the CD DMA engine, driving DMA_RUNNING.

Parameters:
- READY_HOLD, 16'd64, clk_sys cycles SECTOR_READY stays high; it also sets the minimum low gap before the next assertion.
- DATA_WORDS, 11'd1024, data words per sector (2048 bytes).

Ports:
- clk_sys  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- LOAD_WR  in  1  one-cycle strobe; LOAD_DATA valid
- LOAD_DATA  in  16  sector word, big-endian byte order (high byte first)
- LOAD_READY  out  1  high when a bank is free for writing
- OVERFLOW  out  1  sticky; set when LOAD_WR arrives while LOAD_READY=0
- OVF_CLR  in  1  clears OVERFLOW
- HEADER_DOUT  out  32  {mode,frame,sec,min} as bytes [31:24..7:0]; feeds CDC HEADER_DIN
- SECTOR_READY  out  1  pulse per completed sector
- DMA_START  in  1  one-cycle request to begin transfer of the oldest full bank
- DMA_LEN  in  11  words to transfer; 0 means 1024; values >1024 are clamped to 1024
- DMA_RD  in  1  one-cycle read strobe
- DMA_DOUT  out  16  read data
- DMA_RUNNING  out  1  high while a transfer is in progress
- BANKS_FULL  out  2  count of full banks (0..2)

Behaviour:
- Reset: all outputs 0 except LOAD_READY=1; all bank state cleared, both banks empty. Reset asserted mid-transfer or mid-fill aborts everything immediately.
- Storage: 2 banks x 1024 x 16 block RAM, plus a 32-bit header register per bank. Write bank pointer WB and read bank pointer RB are 1 bit each; full flags F[1:0].
- Write side, word index WI 0..1025:
  - WI 0-1 form the header: word0 = {min,sec}, word1 = {frame,mode}, latched into the bank header.
  - WI 2..1025 are written to RAM address WI-2.
  - On the write of WI=1025: F[WB]<=1, WB toggles, WI<=0, and one entry is pushed to the ready-pending counter (saturates at 2).
- LOAD_READY = ~F[WB]. A LOAD_WR while LOAD_READY=0 is dropped and sets OVERFLOW; OVF_CLR has priority over a simultaneous set.
- Ready FSM states: IDLE, HOLD, GAP.
  - IDLE -> HOLD when pending>0. On entry: HEADER_DOUT <= header of the oldest un-announced bank, SECTOR_READY<=1, pending decrements.
  - HOLD -> GAP after READY_HOLD cycles; SECTOR_READY<=0.
  - GAP -> IDLE after READY_HOLD cycles.
  - This guarantees a clean rising edge per sector at the 68k enable rate.
- DMA FSM states: IDLE, RUN.
  - IDLE: DMA_START with F[RB]=1 -> RUN; word counter <= effective length; RAM address <= 0; DMA_RUNNING<=1 on the next cycle.
  - IDLE: DMA_START with no full bank is ignored.
  - RUN: each DMA_RD produces the next word on DMA_DOUT exactly one cycle later (registered RAM read) and increments the address.
  - RUN: when the counter reaches 0 after the last read's data is presented, DMA_RUNNING<=0, F[RB]<=0, RB toggles. The unread remainder of the bank is discarded.
  - RUN: DMA_RD in IDLE, or DMA_START during RUN, is ignored; DMA_DOUT holds its last value.
- Simultaneous bank fill and bank release in one cycle: both take effect; BANKS_FULL stays unchanged.
- Fill and release of the same bank cannot coincide, since a bank being filled is never full.
- BANKS_FULL = F[0]+F[1], registered.

Optional Feature:
- Macro: CD_RAW_SECTOR_EN.
- Defined: the loader supplies raw 2352-byte sectors (1176 words). WI 0-5 (sync) are discarded; WI 6-7 are the header; WI 8..1031 are data; WI 1032..1175 (EDC/ECC) are discarded. The sector completes on WI=1175.
- Undefined: the 1026-word cooked format is used, and the WI counter is 11 bits.

Test Plan:
- Load 1 sector with header 00 02 10 01 and data = address -> LOAD_READY stays 1; SECTOR_READY high for exactly 64 cycles; HEADER_DOUT = 32'h01100200; BANKS_FULL = 1.
- DMA_START with DMA_LEN=0, then 1024 DMA_RD -> DMA_DOUT = 0x0000..0x03FF, each one cycle after its strobe; DMA_RUNNING falls after the last word; BANKS_FULL = 0.
- Load 3 sectors back-to-back with no DMA -> LOAD_READY drops after sector 2; the first word of sector 3 sets OVERFLOW; two SECTOR_READY pulses with a 64-cycle gap; OVF_CLR clears the flag.
- DMA_LEN=4 on a full bank -> 4 words out, bank released, the next DMA starts at word 0 of the other bank.
- Sector 2 completes in the same cycle as DMA release of sector 1 -> BANKS_FULL stays 1; no write is lost.
- Assert nRESET mid-fill and mid-DMA -> DMA_RUNNING=0 and SECTOR_READY=0 asynchronously, LOAD_READY=1, BANKS_FULL=0. With CD_RAW_SECTOR_EN defined: a 1176-word sector yields the header from words 6-7 and data from words 8..1031.
